// File: rtl/sram_pattern_tester.sv
// sram_pattern_tester
//
// Built-in self-test engine for a synchronous SRAM. A run writes a pattern
// over addresses 0..addr_last, turns the bus around, reads the range back and
// compares every returned word with the regenerated pattern. It reports
// pass/fail, a saturating error count and the first failing address.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               begin a run (accepted only in IDLE or DONE)
//   mode, seed          pattern select and seed, latched on start
//   addr_last           last address of the tested range, latched on start
//   mem_addr/mem_wdata/mem_write_enable  registered SRAM request
//   mem_rdata           SRAM read data, READ_LATENCY cycles after its address
//   busy, done, pass    run status
//   error_count         saturating mismatch count
//   first_error_addr/first_error_valid   first mismatching address of the run
module sram_pattern_tester #(
    parameter int ADDR_WIDTH      = 20,
    parameter int DATA_WIDTH      = 18,
    parameter int READ_LATENCY    = 2,
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [DATA_WIDTH-1:0]      seed,
    input  logic [ADDR_WIDTH-1:0]      addr_last,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       mem_write_enable,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_COUNT_WIDTH-1:0] error_count,
    output logic [ADDR_WIDTH-1:0]      first_error_addr,
    output logic                       first_error_valid
);
    localparam int FL_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(READ_LATENCY - 1);
    localparam logic [ERR_COUNT_WIDTH-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_TURN, S_READ, S_FLUSH, S_DONE
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] s,
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] onehot
    );
        logic [DATA_WIDTH-1:0] a_ext;
        a_ext = DATA_WIDTH'(a);
        case (m)
            2'd0:    pattern = a_ext ^ s;
            2'd1:    pattern = onehot;
            2'd2:    pattern = a[0] ? ~s : s;
            default: pattern = ~(a_ext ^ s);
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rotl1(input logic [DATA_WIDTH-1:0] v);
        rotl1 = {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
    endfunction

    state_t                     r_state, w_state_nxt;
    logic [1:0]                 r_mode;
    logic [DATA_WIDTH-1:0]      r_seed;
    logic [ADDR_WIDTH-1:0]      r_last;
    logic [DATA_WIDTH-1:0]      r_onehot, w_onehot_nxt;
    logic [FL_W-1:0]            r_flush, w_flush_nxt;
    logic                       r_mem_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0]      r_mem_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0]      r_mem_wdata;
    logic                       w_issue_nxt, w_start_acc;
    logic [1:0]                 w_mode_eff;
    logic [DATA_WIDTH-1:0]      w_seed_eff, w_pat;
    logic                       w_mismatch;

    // Read-compare pipeline; stage 0 is aligned with the address on mem_addr,
    // stage READ_LATENCY with the word on mem_rdata.
    logic                       r_vld_p  [0:READ_LATENCY];
    logic [ADDR_WIDTH-1:0]      r_addr_p [0:READ_LATENCY];
    logic [DATA_WIDTH-1:0]      r_exp_p  [0:READ_LATENCY];

    logic [ERR_COUNT_WIDTH-1:0] r_err;
    logic [ADDR_WIDTH-1:0]      r_first_addr;
    logic                       r_first_vld;

    // Next-cycle bus request. The SRAM outputs are registered, so everything
    // here describes the cycle that follows the coming edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_we_nxt     = 1'b0;
        w_issue_nxt  = 1'b0;
        w_addr_nxt   = '0;
        w_onehot_nxt = r_onehot;
        w_flush_nxt  = r_flush;
        w_start_acc  = 1'b0;
        w_mode_eff   = r_mode;
        w_seed_eff   = r_seed;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt  = S_WRITE;
                    w_we_nxt     = 1'b1;
                    w_onehot_nxt = DATA_WIDTH'(1);
                    w_start_acc  = 1'b1;
                    // Registers latch on this edge; use the live inputs for word 0.
                    w_mode_eff   = mode;
                    w_seed_eff   = seed;
                end
            end
            S_WRITE: begin
                // End detected by equality so addr_last = all-ones terminates.
                if (r_mem_addr == r_last) begin
                    w_state_nxt = S_TURN;
                end else begin
                    w_we_nxt     = 1'b1;
                    w_addr_nxt   = r_mem_addr + 1'b1;
                    w_onehot_nxt = rotl1(r_onehot);
                end
            end
            S_TURN: begin
                w_state_nxt  = S_READ;
                w_issue_nxt  = 1'b1;
                w_onehot_nxt = DATA_WIDTH'(1);
            end
            S_READ: begin
                if (r_mem_addr == r_last) begin
                    w_state_nxt = S_FLUSH;
                    w_flush_nxt = '0;
                end else begin
                    w_issue_nxt  = 1'b1;
                    w_addr_nxt   = r_mem_addr + 1'b1;
                    w_onehot_nxt = rotl1(r_onehot);
                end
            end
            S_FLUSH: begin
                if (r_flush == FL_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_flush_nxt = r_flush + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_pat = pattern(w_mode_eff, w_seed_eff, w_addr_nxt, w_onehot_nxt);
    end

    assign w_mismatch = r_vld_p[READ_LATENCY] && (mem_rdata != r_exp_p[READ_LATENCY]);

    // Control and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_flush      <= '0;
            r_err        <= '0;
            r_first_addr <= '0;
            r_first_vld  <= 1'b0;
            for (int j = 0; j <= READ_LATENCY; j++) r_vld_p[j] <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_we_nxt ? w_pat : '0;
            r_flush     <= w_flush_nxt;
            r_vld_p[0]  <= w_issue_nxt;
            for (int j = 1; j <= READ_LATENCY; j++) r_vld_p[j] <= r_vld_p[j-1];
            if (w_start_acc) begin
                r_err        <= '0;
                r_first_addr <= '0;
                r_first_vld  <= 1'b0;
            end else if (w_mismatch) begin
                if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
                if (!r_first_vld) begin
                    r_first_vld  <= 1'b1;
                    r_first_addr <= r_addr_p[READ_LATENCY];
                end
            end
        end
    end

    // Run parameters and pipeline payload
    always_ff @(posedge clk) begin
        if (w_start_acc) begin
            r_mode <= mode;
            r_seed <= seed;
            r_last <= addr_last;
        end
        r_onehot    <= w_onehot_nxt;
        r_addr_p[0] <= w_addr_nxt;
        r_exp_p[0]  <= w_pat;
        for (int j = 1; j <= READ_LATENCY; j++) begin
            r_addr_p[j] <= r_addr_p[j-1];
            r_exp_p[j]  <= r_exp_p[j-1];
        end
    end

    assign mem_addr          = r_mem_addr;
    assign mem_wdata         = r_mem_wdata;
    assign mem_write_enable  = r_mem_we;
    assign busy              = r_state inside {S_WRITE, S_TURN, S_READ, S_FLUSH};
    assign done              = (r_state == S_DONE);
    assign pass              = done && (r_err == '0);
    assign error_count       = r_err;
    assign first_error_addr  = r_first_addr;
    assign first_error_valid = r_first_vld;

endmodule

// File: tb/tb_sram_pattern_tester.sv
// tb_sram_pattern_tester
//
// Scoreboard bench: a driver issues runs and pushes the expected outcome of
// each run (computed from the pattern rules and a memory fault model) into a
// queue; a monitor pops and compares whenever done rises. A behavioural SRAM
// with configurable read latency and fault injection answers the DUT.
module tb_sram_pattern_tester;
    localparam int AW   = 8;
    localparam int DW   = 18;
    localparam int RL   = 2;
    localparam int EW   = 4;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] seed = '0;
    logic [AW-1:0] addr_last = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_write_enable;
    logic          busy, done, pass;
    logic [EW-1:0] error_count;
    logic [AW-1:0] first_error_addr;
    logic          first_error_valid;

    sram_pattern_tester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .ERR_COUNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .addr_last(addr_last), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_write_enable(mem_write_enable),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .first_error_addr(first_error_addr), .first_error_valid(first_error_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    endtask

    // ---------------- memory model with fault injection ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int hist [0:RL];
    int fault_mode = 0;
    int bad_addr = 0;
    int bad_bit = 0;
    int wr_cnt = 0;

    function automatic logic [DW-1:0] fault_rd(input logic [DW-1:0] w, input int a);
        case (fault_mode)
            0:       return w;
            1:       return w | DW'(8);
            2:       return ~w;
            default: return (a == bad_addr) ? (w ^ (DW'(1) << bad_bit)) : w;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i <= RL; i++) hist[i] = 0;
    end

    // Sampled mid-cycle: the request of this cycle is stable; the word for the
    // address issued RL cycles ago is presented for the DUT's next edge.
    always @(negedge clk) begin
        if (mem_write_enable) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
        end
        for (int i = RL; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(mem_addr);
        mem_rdata = fault_rd(mem[hist[RL]], hist[RL]);
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] ref_pat(input int m, input logic [DW-1:0] s, input int a);
        logic [DW-1:0] av;
        av = DW'(a);
        case (m)
            0:       return av ^ s;
            1:       return DW'(1) << (a % DW);
            2:       return (a % 2 == 0) ? s : ~s;
            default: return ~(av ^ s);
        endcase
    endfunction

    typedef struct {
        int cnt;
        int faddr;
        bit fvalid;
        bit pass;
        int done_cyc;
        int writes;
    } exp_t;

    exp_t sb_q[$];

    // ---------------- monitor ----------------
    bit   prev_done = 1'b0;
    bit   prev_busy = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_cycle", cyc, mon_e.done_cyc);
                chk("error_count", error_count, mon_e.cnt);
                chk("pass", pass, mon_e.pass);
                chk("first_error_valid", first_error_valid, mon_e.fvalid);
                chk("first_error_addr", first_error_addr, mon_e.faddr);
                chk("write_count", wr_cnt, mon_e.writes);
                chk("busy_falls_with_done", {prev_busy, busy}, 2'b10);
                chk("idle_bus", {mem_write_enable, mem_addr, mem_wdata}, 0);
            end
        end
        prev_done = done;
        prev_busy = busy;
    end

    // ---------------- driver ----------------
    task automatic run(input int m, input logic [DW-1:0] s, input int last,
                       input int f, input bit disturb);
        exp_t e;
        int n, bad;
        logic [DW-1:0] w;
        n = last + 1;
        fault_mode = f;
        e.cnt = 0; e.fvalid = 0; e.faddr = 0;
        for (int a = 0; a < n; a++) begin
            w = ref_pat(m, s, a);
            if (fault_rd(w, a) != w) begin
                if (e.cnt < EMAX) e.cnt++;
                if (!e.fvalid) begin
                    e.fvalid = 1'b1;
                    e.faddr  = a;
                end
            end
        end
        e.pass   = (e.cnt == 0);
        e.writes = n;
        @(negedge clk);
        mode = 2'(m); seed = s; addr_last = AW'(last); start = 1'b1;
        wr_cnt = 0;
        e.done_cyc = cyc + 1 + 2 * n + 1 + RL;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            repeat (n + 3) @(negedge clk);
            start = 1'b1;
            mode  = 2'($urandom_range(1, 3));
            seed  = DW'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 2 * n + RL + 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb_q.delete();
        end
        bad = 0;
        for (int a = 0; a < n; a++) if (mem[a] != ref_pat(m, s, a)) bad++;
        chk("mem_image_bad_words", bad, 0);
    endtask

    task automatic reset_mid_write();
        @(negedge clk);
        mode = 2'd0; seed = DW'($urandom); addr_last = AW'(20); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("we_before_reset", mem_write_enable, 1);
        chk("addr_before_reset", mem_addr, 4);
        #1 rst = 1'b1;
        #1;
        chk("we_async_reset", mem_write_enable, 0);
        chk("busy_async_reset", busy, 0);
        chk("outputs_async_reset",
            {done, pass, first_error_valid, error_count, mem_addr, mem_wdata, first_error_addr}, 0);
        repeat (2) @(negedge clk);
        chk("no_write_in_reset", mem_write_enable, 0);
        rst = 1'b0;
    endtask

    initial begin
        int m, last, f;
        #1 rst = 1'b1;
        #1;
        chk("reset_outputs",
            {busy, done, pass, first_error_valid, error_count, mem_write_enable,
             mem_addr, mem_wdata, first_error_addr}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run(0, '0, 15, 0, 1'b0);                       // clean run, 35 cycles
        run(2, '0, 7, 1, 1'b0);                        // bit 3 stuck at 1
        run(1, DW'($urandom), 0, 0, 1'b0);             // single word
        reset_mid_write();
        run(0, DW'($urandom), 20, 0, 1'b0);            // full run after reset
        run(0, DW'($urandom), 31, 2, 1'b0);            // inverted reads, saturation
        run(0, DW'($urandom), 16, 0, 1'b1);            // inputs disturbed mid-read

        for (int r = 0; r < 8; r++) begin
            m        = int'($urandom_range(0, 3));
            last     = int'($urandom_range(0, 40));
            f        = int'($urandom_range(0, 3));
            bad_addr = int'($urandom_range(0, last));
            bad_bit  = int'($urandom_range(0, DW - 1));
            run(m, DW'($urandom), last, f, 1'b0);
        end

        bad_addr = (1 << AW) - 1;
        bad_bit  = int'($urandom_range(0, DW - 1));
        run(int'($urandom_range(0, 3)), DW'($urandom), (1 << AW) - 1, 3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
